// File: rtl/if_id_pipe_reg.sv
// ============================================================================
// Module   : if_id_pipe_reg
// Brief    : IF/ID pipeline register with stall hold, redirect bubble
//            injection and valid tracking. Optional perf counters are
//            enabled by defining IF_ID_PERF_EN.
// Revision : 1.0 - parametrised successor of the fixed 32-bit IF/ID latch
// ============================================================================
`default_nettype none

module if_id_pipe_reg #(
  parameter int                 PC_W         = 32,
  parameter int                 INSTR_W      = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR    = 32'h0000_0013,
  parameter int                 FLUSH_CYCLES = 2,
  parameter logic [PC_W-1:0]    RESET_PC     = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               in_valid,
  input  logic               stall,
  input  logic               redirect,
  output logic [PC_W-1:0]    pc_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               out_valid,
  output logic               flushing
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        bubble_cycles
`endif
);

  generate
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush_cycles
      $error("if_id_pipe_reg: FLUSH_CYCLES must be in 1..7");
    end
  endgenerate

  // The redirect edge itself is the first bubble, so the counter covers the rest.
  localparam logic [2:0] c_FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_valid;
  logic [2:0]         r_flush_cnt;
  logic               w_flush_active;

  assign w_flush_active = (r_flush_cnt != 3'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_instr     <= NOP_INSTR;
      r_valid     <= 1'b0;
      r_flush_cnt <= 3'd0;
    end else if (redirect) begin
      r_pc        <= pc_in;
      r_instr     <= NOP_INSTR;
      r_valid     <= 1'b0;
      r_flush_cnt <= c_FLUSH_RELOAD;
    end else if (!stall) begin
      r_pc <= pc_in;
      if (w_flush_active) begin
        r_instr     <= NOP_INSTR;
        r_valid     <= 1'b0;
        r_flush_cnt <= r_flush_cnt - 3'd1;
      end else if (!in_valid) begin
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end else begin
        r_instr <= instr_in;
        r_valid <= 1'b1;
      end
    end
  end

  assign pc_out    = r_pc;
  assign instr_out = r_instr;
  assign out_valid = r_valid;
  assign flushing  = w_flush_active;

`ifdef IF_ID_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_bubble_cycles;
  logic        w_load_bubble;

  assign w_load_bubble = redirect | (!stall & (w_flush_active | !in_valid));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles  <= 32'd0;
      r_bubble_cycles <= 32'd0;
    end else begin
      if (stall && !redirect) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_load_bubble) begin
        r_bubble_cycles <= r_bubble_cycles + 32'd1;
      end
    end
  end

  assign stall_cycles  = r_stall_cycles;
  assign bubble_cycles = r_bubble_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_id_pipe_reg.sv
// Bench for if_id_pipe_reg: directed vector table plus random traffic checked
// against a rule-level model, on instances with FLUSH_CYCLES = 2, 3 and 1.
`default_nettype none

module tb_if_id_pipe_reg;

  localparam int NI = 3;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] instr_in = '0;
  logic        in_valid = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;

  logic [31:0] pc_out    [NI];
  logic [31:0] instr_out [NI];
  logic        out_valid [NI];
  logic        flushing  [NI];
`ifdef IF_ID_PERF_EN
  logic [31:0] stall_cycles  [NI];
  logic [31:0] bubble_cycles [NI];
`endif

  always #5 clk = ~clk;

  function automatic int fc_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 3 : 1;
  endfunction

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      if_id_pipe_reg #(
        .PC_W(32), .INSTR_W(32), .NOP_INSTR(NOP),
        .FLUSH_CYCLES((g == 0) ? 2 : (g == 1) ? 3 : 1), .RESET_PC(32'h0)
      ) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in),
        .in_valid(in_valid), .stall(stall), .redirect(redirect),
        .pc_out(pc_out[g]), .instr_out(instr_out[g]),
        .out_valid(out_valid[g]), .flushing(flushing[g])
`ifdef IF_ID_PERF_EN
        , .stall_cycles(stall_cycles[g]), .bubble_cycles(bubble_cycles[g])
`endif
      );
    end
  endgenerate

  // Rule-level model: m_left counts forced bubbles still owed after this one.
  logic [31:0] m_pc    [NI];
  logic [31:0] m_instr [NI];
  logic        m_valid [NI];
  int          m_left  [NI];
  int unsigned m_stall [NI];
  int unsigned m_bub   [NI];

  int checks = 0;
  int errors = 0;

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_pc[i] = 32'h0; m_instr[i] = NOP; m_valid[i] = 1'b0; m_left[i] = 0;
      m_stall[i] = 0; m_bub[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      if (redirect) begin
        m_pc[i] = pc_in; m_instr[i] = NOP; m_valid[i] = 1'b0;
        m_left[i] = fc_of(i) - 1; m_bub[i]++;
      end else if (stall) begin
        m_stall[i]++;
      end else begin
        m_pc[i] = pc_in;
        if (m_left[i] > 0) begin
          m_instr[i] = NOP; m_valid[i] = 1'b0; m_left[i]--; m_bub[i]++;
        end else if (!in_valid) begin
          m_instr[i] = NOP; m_valid[i] = 1'b0; m_bub[i]++;
        end else begin
          m_instr[i] = instr_in; m_valid[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < NI; i++) begin
      logic [65:0] act, exp;
      act = {pc_out[i], instr_out[i], out_valid[i], flushing[i]};
      exp = {m_pc[i], m_instr[i], m_valid[i], (m_left[i] != 0)};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s inst%0d {pc,instr,valid,flushing}: got %h expected %h", tag, i, act, exp);
      end
`ifdef IF_ID_PERF_EN
      checks++;
      if ({stall_cycles[i], bubble_cycles[i]} !== {m_stall[i], m_bub[i]}) begin
        errors++;
        $display("FAIL %s inst%0d perf {stall,bubble}: got %0d/%0d expected %0d/%0d",
                 tag, i, stall_cycles[i], bubble_cycles[i], m_stall[i], m_bub[i]);
      end
`endif
    end
  endtask

  task automatic check_const(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                             input logic v, input logic f);
    checks++;
    if ({pc_out[0], instr_out[0], out_valid[0], flushing[0]} !== {pc, ins, v, f}) begin
      errors++;
      $display("FAIL %s: got pc=%h instr=%h valid=%b flushing=%b expected pc=%h instr=%h valid=%b flushing=%b",
               tag, pc_out[0], instr_out[0], out_valid[0], flushing[0], pc, ins, v, f);
    end
  endtask

  task automatic step(input logic s, input logic r, input logic v,
                      input logic [31:0] p, input logic [31:0] ins);
    stall = s; redirect = r; in_valid = v; pc_in = p; instr_in = ins;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic        s, r, v;
    logic [31:0] p, ins;
    logic [31:0] e_pc, e_ins;
    logic        e_v, e_f;
  } vec_t;

  vec_t tbl [18];

  initial begin
    tbl[0]  = '{0,0,1, 32'h100, 32'h0050_0093, 32'h100, 32'h0050_0093, 1, 0};
    tbl[1]  = '{0,0,1, 32'h104, 32'h00a0_0113, 32'h104, 32'h00a0_0113, 1, 0};
    tbl[2]  = '{1,0,1, 32'h108, 32'hDEAD_BEEF, 32'h104, 32'h00a0_0113, 1, 0};
    tbl[3]  = '{0,0,1, 32'h108, 32'hDEAD_BEEF, 32'h108, 32'hDEAD_BEEF, 1, 0};
    tbl[4]  = '{0,1,1, 32'h10C, 32'h1111_1111, 32'h10C, NOP,           0, 1};
    tbl[5]  = '{0,0,1, 32'h200, 32'h2222_2222, 32'h200, NOP,           0, 0};
    tbl[6]  = '{0,0,1, 32'h204, 32'h3333_3333, 32'h204, 32'h3333_3333, 1, 0};
    tbl[7]  = '{0,1,1, 32'h300, 32'h4444_0000, 32'h300, NOP,           0, 1};
    tbl[8]  = '{1,0,1, 32'h304, 32'h4444_4444, 32'h300, NOP,           0, 1};
    tbl[9]  = '{0,0,1, 32'h304, 32'h4444_4444, 32'h304, NOP,           0, 0};
    tbl[10] = '{0,0,1, 32'h308, 32'h5555_5555, 32'h308, 32'h5555_5555, 1, 0};
    tbl[11] = '{1,1,1, 32'h400, 32'h6666_0000, 32'h400, NOP,           0, 1};
    tbl[12] = '{0,1,1, 32'h404, 32'h6666_1111, 32'h404, NOP,           0, 1};
    tbl[13] = '{0,0,1, 32'h408, 32'h6666_6666, 32'h408, NOP,           0, 0};
    tbl[14] = '{0,0,1, 32'h40C, 32'h7777_7777, 32'h40C, 32'h7777_7777, 1, 0};
    tbl[15] = '{0,0,0, 32'h500, 32'h8888_8888, 32'h500, NOP,           0, 0};
    tbl[16] = '{0,0,1, 32'h504, 32'h9999_9999, 32'h504, 32'h9999_9999, 1, 0};
    tbl[17] = '{1,0,1, 32'h508, 32'hAAAA_0000, 32'h504, 32'h9999_9999, 1, 0};

    #2 rst = 1'b1;
    model_reset();
    #1;
    check_const("reset_state", 32'h0, NOP, 1'b0, 1'b0);
    check_model("reset_model");
    @(posedge clk); #1;
    check_const("reset_held", 32'h0, NOP, 1'b0, 1'b0);
    #2 rst = 1'b0;

    for (int k = 0; k < 18; k++) begin
      step(tbl[k].s, tbl[k].r, tbl[k].v, tbl[k].p, tbl[k].ins);
      check_const($sformatf("vec%0d", k), tbl[k].e_pc, tbl[k].e_ins, tbl[k].e_v, tbl[k].e_f);
      check_model($sformatf("vec%0d_model", k));
    end

`ifdef IF_ID_PERF_EN
    checks++;
    if (stall_cycles[0] !== 32'd3 || bubble_cycles[0] !== 32'd8) begin
      errors++;
      $display("FAIL perf_after_table: got stall=%0d bubble=%0d expected stall=3 bubble=8",
               stall_cycles[0], bubble_cycles[0]);
    end
`endif

    // Asynchronous reset in the middle of a flush, then normal capture.
    step(0, 1, 1, 32'h600, 32'hBBBB_0000);
    check_const("flush_before_rst", 32'h600, NOP, 1'b0, 1'b1);
    #3 rst = 1'b1;
    model_reset();
    #1;
    check_const("async_rst_midflush", 32'h0, NOP, 1'b0, 1'b0);
    check_model("async_rst_model");
    rst = 1'b0;
    step(0, 0, 1, 32'h604, 32'hAAAA_AAAA);
    check_const("post_rst_capture", 32'h604, 32'hAAAA_AAAA, 1'b1, 1'b0);

    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 4) != 0, $urandom, $urandom);
      check_model("random");
      if ($urandom_range(0, 99) == 0) begin
        #3 rst = 1'b1;
        model_reset();
        #1;
        check_model("random_rst");
        rst = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
- Parametrised IF/ID pipeline register, successor to the fixed 32-bit fetch/decode latch.
- Captures PC and instruction from fetch and presents them to decode.
- Supports a load-use stall (hold), a branch/jump redirect that injects a configurable number of NOP bubbles, and a valid bit for downstream hazard logic.
- Sits between the fetch unit (PC mux plus instruction memory) and the decode/register-read stage.

Parameters:
- PC_W, 32, width of PC field.
- INSTR_W, 32, width of instruction field.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0), INSTR_W bits.
- FLUSH_CYCLES, 2, bubbles injected per redirect; legal range 1..7.
- RESET_PC, 0, PC_W-bit value of pc_out after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_in  in  PC_W  PC of the fetched instruction.
- instr_in  in  INSTR_W  fetched instruction.
- in_valid  in  1  fetch output is meaningful this cycle.
- stall  in  1  load-use hazard; hold the stage contents.
- redirect  in  1  branch taken or jump resolved; kill younger instructions.
- pc_out  out  PC_W  registered PC to decode.
- instr_out  out  INSTR_W  registered instruction to decode.
- out_valid  out  1  instr_out is a real instruction, not a bubble.
- flushing  out  1  flush counter is non-zero (bubble injection in progress).

Behaviour:
- Reset (async, immediate):
  - pc_out=RESET_PC, instr_out=NOP_INSTR, out_valid=0, flush_cnt=0, flushing=0.
  - Reset asserted mid-flush or mid-stall aborts the flush or stall. First post-reset edge follows the normal rules.
- All outputs are registered. Latency from input to output is 1 cycle. flushing = (flush_cnt != 0), driven combinationally from the register.
- flush_cnt is a 3-bit down-counter.
- Per rising edge, in priority order:
  1. redirect=1: instr_out<=NOP_INSTR, out_valid<=0, pc_out<=pc_in, flush_cnt<=FLUSH_CYCLES-1. Redirect overrides stall and in_valid. A redirect during an active flush reloads the counter and does not accumulate.
  2. stall=1: pc_out, instr_out, out_valid and flush_cnt all hold. A stall during a flush freezes the counter.
  3. flush_cnt!=0: instr_out<=NOP_INSTR, out_valid<=0, pc_out<=pc_in, flush_cnt<=flush_cnt-1.
  4. in_valid=0: instr_out<=NOP_INSTR, out_valid<=0, pc_out<=pc_in.
  5. Otherwise: pc_out<=pc_in, instr_out<=instr_in, out_valid<=1.
- Bubble count: a redirect yields exactly FLUSH_CYCLES consecutive non-stalled cycles with out_valid=0, counting the redirect edge itself. With FLUSH_CYCLES=1, flush_cnt stays 0 and flushing never asserts.
- Stall and redirect in the same cycle: redirect wins; the stall is dropped.
- Values outside FLUSH_CYCLES 1..7 are illegal; the block flags them with an elaboration-time error.

Optional Feature:
- Macro IF_ID_PERF_EN.
- Defined:
  - Adds outputs stall_cycles[31:0] and bubble_cycles[31:0], both reset to 0.
  - stall_cycles increments on every edge where stall=1 and redirect=0.
  - bubble_cycles increments on every edge that loads a bubble (rules 1, 3, 4).
  - Both counters wrap from 0xFFFF_FFFF to 0.
- Undefined: those ports and their logic are absent. Core behaviour is identical.

Test Plan:
- Reset, then in_valid=1 with pc_in=0x100, instr_in=0x00500093 -> next cycle pc_out=0x100, instr_out=0x00500093, out_valid=1. During reset: pc_out=0, instr_out=0x13, out_valid=0.
- Stall: at pc 0x104 assert stall 1 cycle while pc_in/instr_in change to 0x108/0xDEADBEEF -> pc_out/instr_out stay 0x104/prior instruction for one extra cycle, then 0x108/0xDEADBEEF.
- Redirect with FLUSH_CYCLES=2: redirect at edge N -> out_valid=0 and instr_out=0x13 after edges N and N+1; flushing=1 after N only; first valid instruction appears after edge N+2.
- Stall during flush: redirect at N, stall at N+1 -> bubble held, counter frozen; the second bubble loads at N+2; valid resumes at N+3.
- Simultaneous stall+redirect, plus a second redirect at N+1 -> bubbles continue through N+2. With FLUSH_CYCLES=3, the counter reloads to 2.
- IF_ID_PERF_EN: 3 stall cycles + 1 redirect (FLUSH_CYCLES=2) + 1 cycle of in_valid=0 -> stall_cycles=3, bubble_cycles=3. Async reset mid-run clears both counters to 0.
